multdiv_unit: RTL

Multicycle signed 32-bit multiply/divide unit that sits directly downstream of the processor's execute stage. The processor asserts a one-cycle start strobe on `mul` or `div` with both operands, stalls its pipeline, and waits for `data_resultRDY`. The result then returns to the writeback path. Overflow and divide-by-zero are flagged through `data_exception` so the processor can write `rstatus`.

---
 rtl/multdiv_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multicycle signed 32-bit multiply/divide unit
// Shift-add multiply and restoring divide on magnitudes, one bit per clock, sign fixed at the end.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] shreg_q, shreg_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic [31:0] pres_q, pres_d;
  logic        pexc_q, pexc_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_acc, prod_s;
  logic [32:0] rem_sh, rem_n;
  logic        ge;
  logic [31:0] q_n;

  function automatic logic [31:0] mag(input logic [31:0] x);
    mag = x[31] ? (~x + 32'd1) : x;
  endfunction

  always_comb begin
    a_mag    = mag(data_operandA);
    b_mag    = mag(data_operandB);
    prod_acc = acc_q + (shreg_q[0] ? mcand_q : 64'd0);
    prod_s   = neg_q ? (~prod_acc + 64'd1) : prod_acc;
    rem_sh   = {acc_q[31:0], shreg_q[31]};
    ge       = (rem_sh >= {1'b0, mcand_q[31:0]});
    rem_n    = ge ? (rem_sh - {1'b0, mcand_q[31:0]}) : rem_sh;
    q_n      = {shreg_q[30:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    shreg_d = shreg_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    pres_d  = pres_q;
    pexc_d  = pexc_q;
    res_d   = res_q;
    exc_d   = 1'b0;
    rdy_d   = 1'b0;

    case (state_q)
      S_MULT: begin
        acc_d   = prod_acc;
        mcand_d = mcand_q << 1;
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          pres_d  = prod_s[31:0];
          // Overflow when the upper 33 bits are not a pure sign extension.
          pexc_d  = !((prod_s[63:31] == '0) || (prod_s[63:31] == '1));
        end
      end
      S_DIV: begin
        acc_d   = {31'd0, rem_n};
        shreg_d = q_n;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          pres_d  = neg_q ? (~q_n + 32'd1) : q_n;
          pexc_d  = ovf_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        res_d   = pres_q;
        exc_d   = pexc_q;
        rdy_d   = 1'b1;
      end
      default: ;
    endcase

    // A strobe always (re)starts, discarding any operation in flight.
    if (ctrl_MULT || ctrl_DIV) begin
      cnt_d = 5'd0;
      acc_d = 64'd0;
      neg_d = data_operandA[31] ^ data_operandB[31];
      ovf_d = 1'b0;
      if (ctrl_MULT) begin
        state_d = S_MULT;
        mcand_d = {32'd0, a_mag};
        shreg_d = b_mag;
      end else if (data_operandB == 32'd0) begin
        state_d = S_DONE;
        pres_d  = 32'd0;
        pexc_d  = 1'b1;
      end else begin
        state_d = S_DIV;
        mcand_d = {32'd0, b_mag};
        shreg_d = a_mag;
        ovf_d   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end
    end

    busy_d = (state_d == S_MULT) || (state_d == S_DIV);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      mcand_q <= 64'd0;
      shreg_q <= 32'd0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pres_q  <= 32'd0;
      pexc_q  <= 1'b0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shreg_q <= shreg_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      pres_q  <= pres_d;
      pexc_q  <= pexc_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule
